// File: rtl/cpu_pkg.sv
// Shared encodings for the fetch stage: jump-select codes, opcodes and fetch FSM states.
package cpu_pkg;

    localparam logic [1:0] JUMP_TARGET = 2'b00;
    localparam logic [1:0] JUMP_SEQ    = 2'b01;
    localparam logic [1:0] JUMP_REG    = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_REQ   = 2'b01,
        S_VALID = 2'b10,
        S_FAULT = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection from the decoder's jump/branch controls.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_index,
    input  logic [1:0]  jump_sel,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] branch_offset;

    // 16-bit word offset lives in the low half of the j-index field
    assign branch_offset = {{14{instr_index[15]}}, instr_index[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (jump_sel)
            JUMP_TARGET: next_pc = {pc_plus4[31:28], instr_index, 2'b00};
            JUMP_REG:    next_pc = jr_target;
            default:     next_pc = (branch && zero) ? (pc_plus4 + branch_offset) : pc_plus4;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches over an imem req/ack handshake and holds the
// instruction for the decoder until the core retires it.
//
//  state   | meaning
//  S_IDLE  | just out of reset, start fetching next edge
//  S_REQ   | imem_req_o high at pc, waiting for ack (bounded by TIMEOUT)
//  S_VALID | instr_o valid, waiting for retire_i
//  S_FAULT | misaligned target or fetch timeout; left only by reset
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic        retire_i,
    input  logic [1:0]  jump_sel_i,
    input  logic        branch_i,
    input  logic        zero_i,
    input  logic [31:0] jr_target_i,
    output logic        fault_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    fetch_state_t  state;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          req;
    logic          valid;
    logic          fault;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   pc_plus4;
    logic [31:0]   next_pc;
    logic          misaligned;

    assign pc_plus4 = pc + 32'd4;

    next_pc_calc u_next_pc (
        .pc_plus4    (pc_plus4),
        .instr_index (instr[25:0]),
        .jump_sel    (jump_sel_i),
        .branch      (branch_i),
        .zero        (zero_i),
        .jr_target   (jr_target_i),
        .next_pc     (next_pc),
        .misaligned  (misaligned)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            instr    <= 32'd0;
            req      <= 1'b0;
            valid    <= 1'b0;
            fault    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_REQ;
                    req      <= 1'b1;
                    wait_cnt <= '0;
                end
                S_REQ: begin
                    // ack takes priority over the timeout on the same edge
                    if (imem_ack_i) begin
                        instr <= imem_data_i;
                        state <= S_VALID;
                        req   <= 1'b0;
                        valid <= 1'b1;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        state <= S_FAULT;
                        req   <= 1'b0;
                        fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_VALID: begin
                    if (retire_i) begin
                        pc    <= next_pc;
                        valid <= 1'b0;
                        if (misaligned) begin
                            state <= S_FAULT;
                            fault <= 1'b1;
                        end else begin
                            state    <= S_REQ;
                            req      <= 1'b1;
                            wait_cnt <= '0;
                        end
                    end
                end
                S_FAULT: begin
                    req   <= 1'b0;
                    valid <= 1'b0;
                    fault <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    req   <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = pc;
    assign instr_o       = instr;
    assign instr_valid_o = valid;
    assign pc_o          = pc;
    assign pc_plus4_o    = pc_plus4;
    assign fault_o       = fault;

endmodule
